// File: rtl/reg_write_arbiter_if.sv
// Write-port bundle between the requesters (master) and the register-bank write arbiter (slave).
// Each requester i owns slice i of the packed addr/data/req/lock buses.
interface reg_write_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8,
    parameter int A = 3
);
    logic [N-1:0]        req;
    logic [N*A-1:0]      addr;
    logic [N*W-1:0]      data;
    logic [N-1:0]        lock;
    logic [N-1:0]        gnt;
    logic [(1<<A)-1:0]   wr_en;
    logic [W-1:0]        wr_data;
    logic                busy;

    modport master (
        output req, addr, data, lock,
        input  gnt, wr_en, wr_data, busy
    );

    modport slave (
        input  req, addr, data, lock,
        output gnt, wr_en, wr_data, busy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single write port of a register bank; registered one-hot grant and word enable.
// Define REG_WRITE_ARB_LOCK_EN to honour lock and enable the LOCKED state (back-to-back writes by one holder).
module reg_write_arbiter #(
    parameter int N = 4,
    parameter int W = 8,
    parameter int A = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_write_arbiter_if.slave   bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int D  = 1 << A;

    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   ptr_reg, ptr_next;
    logic [N-1:0]    gnt_reg, gnt_next;
    logic [D-1:0]    wr_en_reg, wr_en_next;
    logic [W-1:0]    wr_data_reg, wr_data_next;
    logic            busy_reg, busy_next;

    logic [A-1:0]    addr_arr [N];
    logic [W-1:0]    data_arr [N];
    logic [N-1:0]    ereq;
    logic            found;
    logic [PW-1:0]   win;
    logic            hold;
    logic            take;
    logic [PW-1:0]   sel;

    // A requester still seeing its grant is masked so it is not written twice,
    // except the current lock holder, whose request is fresh each cycle.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_req
            assign addr_arr[gi] = bus.addr[gi*A +: A];
            assign data_arr[gi] = bus.data[gi*W +: W];
            assign ereq[gi]     = bus.req[gi] &
                                  (~gnt_reg[gi] | ((state_reg == LOCKED) && (ptr_reg == PW'(gi))));
        end
    endgenerate

    // First effective request after the last winner, wrapping modulo N.
    always_comb begin
        logic [PW-1:0] cand;
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int off = 1; off <= N; off++) begin
            cand = PW'((int'(ptr_reg) + off) % N);
            if (!found && ereq[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

`ifdef REG_WRITE_ARB_LOCK_EN
    assign hold = (state_reg != IDLE) && bus.req[ptr_reg] && bus.lock[ptr_reg];
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_next   = IDLE;
        ptr_next     = ptr_reg;
        gnt_next     = '0;
        wr_en_next   = '0;
        wr_data_next = '0;
        busy_next    = 1'b0;
        take         = 1'b0;
        sel          = '0;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    take       = 1'b1;
                    sel        = win;
                    state_next = GRANT;
                end
            end
            GRANT, LOCKED: begin
                if (hold) begin
                    take       = 1'b1;
                    sel        = ptr_reg;
                    state_next = LOCKED;
                end else if (found) begin
                    take       = 1'b1;
                    sel        = win;
                    state_next = GRANT;
                end
            end
            default: state_next = IDLE;
        endcase
        if (take) begin
            ptr_next     = sel;
            gnt_next     = N'(1) << sel;
            wr_en_next   = D'(1) << addr_arr[sel];
            wr_data_next = data_arr[sel];
            busy_next    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= PW'(N - 1);
            gnt_reg     <= '0;
            wr_en_reg   <= '0;
            wr_data_reg <= '0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            gnt_reg     <= gnt_next;
            wr_en_reg   <= wr_en_next;
            wr_data_reg <= wr_data_next;
            busy_reg    <= busy_next;
        end
    end

    assign bus.gnt     = gnt_reg;
    assign bus.wr_en   = wr_en_reg;
    assign bus.wr_data = wr_data_reg;
    assign bus.busy    = busy_reg;
endmodule
